// File: rtl/lsu_pkg.sv
// Shared encodings, state type and byte-mask helper for the load/store controller.
package lsu_pkg;

   localparam int DW_BYTES = 8;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   // Lanes touched across the current and the following doubleword.
   function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
      logic [4:0] nbytes;
      nbytes = 5'd1 << size;
      return ((16'd1 << nbytes) - 16'd1) << off;
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Truncates right-justified load data to the access size and sign/zero-extends it.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [63:0] din,
   output logic [63:0] dout
);

   logic sx;

   always_comb begin
      sx   = 1'b0;
      dout = din;
      case (size)
         SZ_B: begin
            sx   = ~uns & din[7];
            dout = {{56{sx}}, din[7:0]};
         end
         SZ_H: begin
            sx   = ~uns & din[15];
            dout = {{48{sx}}, din[15:0]};
         end
         SZ_W: begin
            sx   = ~uns & din[31];
            dout = {{32{sx}}, din[31:0]};
         end
         SZ_D:    dout = din;
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request per handshake, one or two memory beats, one response.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_ren,
   output logic [63:0] mem_raddr,
   input  logic [63:0] mem_rdata,
   output logic        mem_wen,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask
);

   state_t      state_reg;
   logic        wen_reg;
   logic        uns_reg;
   logic [1:0]  size_reg;
   logic [63:0] addr_reg;
   logic [63:0] wdata_reg;
   logic [63:0] data_reg;
   logic [15:0] bmask_reg;

   logic [15:0] bmask_req;
   logic        cross_req;
   logic        cross_reg;
   logic [5:0]  sh0;
   logic [6:0]  sh1;
   logic [63:0] dw_addr;
   logic [63:0] data_next;
   logic [63:0] ext_data;

   assign req_ready = (state_reg == IDLE);

   always_comb begin
      bmask_req = byte_mask(req_size, req_addr[2:0]);
      cross_req = |bmask_req[15:8];
      cross_reg = |bmask_reg[15:8];
      sh0       = {addr_reg[2:0], 3'b000};
      sh1       = 7'(8 * DW_BYTES) - 7'(sh0);
      dw_addr   = {addr_reg[63:3], 3'b000};
      // Beat0 right-justifies the low part; beat1 fills in the bytes above it.
      data_next = (state_reg == BEAT0) ? (mem_rdata >> sh0)
                                       : (data_reg | (mem_rdata << sh1));
   end

   lsu_extend u_extend (
      .size (size_reg),
      .uns  (uns_reg),
      .din  (data_next),
      .dout (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         wen_reg    <= 1'b0;
         uns_reg    <= 1'b0;
         size_reg   <= 2'd0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         data_reg   <= '0;
         bmask_reg  <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_ren    <= 1'b0;
         mem_wen    <= 1'b0;
         mem_raddr  <= '0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
      end else begin
         // Strobes and bus fields are single-cycle pulses unless re-armed below.
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         mem_raddr <= '0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  wen_reg   <= req_wen;
                  uns_reg   <= req_unsigned;
                  size_reg  <= req_size;
                  addr_reg  <= req_addr;
                  wdata_reg <= req_wdata;
                  bmask_reg <= bmask_req;
                  data_reg  <= '0;
                  state_reg <= BEAT0;
                  if (!(cross_req && !SPLIT_EN)) begin
                     if (req_wen) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= {req_addr[63:3], 3'b000};
                        mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
                        mem_wmask <= bmask_req[7:0];
                     end else begin
                        mem_ren   <= 1'b1;
                        mem_raddr <= {req_addr[63:3], 3'b000};
                     end
                  end
               end
            end
            BEAT0: begin
               if (cross_reg && !SPLIT_EN) begin
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  resp_rdata <= '0;
                  state_reg  <= RESP;
               end else begin
                  data_reg <= data_next;
                  if (cross_reg) begin
                     state_reg <= BEAT1;
                     if (wen_reg) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= dw_addr + 64'(DW_BYTES);
                        mem_wdata <= wdata_reg >> sh1;
                        mem_wmask <= bmask_reg[15:8];
                     end else begin
                        mem_ren   <= 1'b1;
                        mem_raddr <= dw_addr + 64'(DW_BYTES);
                     end
                  end else begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= wen_reg ? '0 : ext_data;
                  end
               end
            end
            BEAT1: begin
               state_reg  <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= wen_reg ? '0 : ext_data;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized traffic against a byte-level model.
module tb_lsu_mem_ctrl;

   typedef struct {
      logic        w;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_wen, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata, mem_rdata;
   logic        req_ready, resp_valid, resp_err, mem_ren, mem_wen;
   logic [63:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
   logic [7:0]  mem_wmask;

   logic        ns_req_valid, ns_resp_ready;
   logic        ns_req_ready, ns_resp_valid, ns_resp_err, ns_mem_ren, ns_mem_wen;
   logic [63:0] ns_resp_rdata, ns_mem_raddr, ns_mem_waddr, ns_mem_wdata;
   logic [7:0]  ns_mem_wmask;

   logic [63:0] dmem [16];
   logic [7:0]  ref_bytes [128];
   beat_t       beats [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_txn = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.SPLIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
   );

   lsu_mem_ctrl #(.SPLIT_EN(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n),
      .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_wen(req_wen),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(ns_resp_valid), .resp_ready(ns_resp_ready),
      .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
      .mem_ren(ns_mem_ren), .mem_raddr(ns_mem_raddr), .mem_rdata(mem_rdata),
      .mem_wen(ns_mem_wen), .mem_waddr(ns_mem_waddr), .mem_wdata(ns_mem_wdata), .mem_wmask(ns_mem_wmask)
   );

   // Memory: applies writes, answers reads, logs every beat, and checks the idle bus.
   always @(negedge clk) begin
      mem_rdata = {$urandom, $urandom};
      n_checks++;
      if ((mem_ren && mem_wen) ||
          (!mem_ren && !mem_wen && ((mem_raddr | mem_waddr | mem_wdata | {56'd0, mem_wmask}) != 64'd0)))
         $display("FAIL bus_idle: ren=%b wen=%b raddr=%h waddr=%h wdata=%h wmask=%h, required exclusive strobes and zero idle bus",
                  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask);
      else
         n_pass++;
      if (mem_wen) begin
         for (int b = 0; b < 8; b++)
            if (mem_wmask[b]) dmem[mem_waddr[6:3]][8*b +: 8] = mem_wdata[8*b +: 8];
         beats.push_back('{1'b1, mem_waddr, mem_wdata, mem_wmask});
      end
      if (mem_ren) begin
         mem_rdata = dmem[mem_raddr[6:3]];
         beats.push_back('{1'b0, mem_raddr, 64'd0, 8'd0});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic poke(input int idx, input logic [63:0] v);
      dmem[idx] = v;
      for (int b = 0; b < 8; b++) ref_bytes[idx*8 + b] = v[8*b +: 8];
   endtask

   function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] size, input logic uns);
      int nb;
      logic [63:0] v, m, a;
      nb = 1 << size;
      v = '0;
      for (int i = 0; i < nb; i++) begin
         a = addr + 64'(i);
         v[8*i +: 8] = ref_bytes[a[6:0]];
      end
      m = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 64'd1);
      if (!uns && v[8*nb-1]) v = v | ~m;
      return v;
   endfunction

   task automatic model_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata);
      logic [63:0] a;
      for (int i = 0; i < (1 << size); i++) begin
         a = addr + 64'(i);
         ref_bytes[a[6:0]] = wdata[8*i +: 8];
      end
   endtask

   task automatic check_mem(input string name);
      int bad;
      bad = -1;
      for (int i = 0; i < 128; i++)
         if (dmem[i/8][8*(i%8) +: 8] !== ref_bytes[i] && bad < 0) bad = i;
      n_checks++;
      if (bad >= 0)
         $display("FAIL %s mem: byte %0d is %h, required %h", name, bad, dmem[bad/8][8*(bad%8) +: 8], ref_bytes[bad]);
      else
         n_pass++;
   endtask

   task automatic check_beats(input string name, input logic wen, input logic [1:0] size,
                              input logic [63:0] addr, input logic [63:0] wdata);
      int nb, off, exp_n;
      logic [15:0] m16;
      logic [63:0] ea;
      logic [7:0]  em;
      logic        ok;
      nb = 1 << size;
      off = int'(addr[2:0]);
      exp_n = (off + nb > 8) ? 2 : 1;
      m16 = '0;
      for (int i = 0; i < nb; i++) m16[off+i] = 1'b1;
      n_checks++;
      if (beats.size() != exp_n)
         $display("FAIL %s beat_count: got %0d, required %0d", name, beats.size(), exp_n);
      else
         n_pass++;
      for (int k = 0; k < beats.size() && k < 2; k++) begin
         ea = {addr[63:3], 3'b000} + 64'(8*k);
         em = wen ? m16[8*k +: 8] : 8'd0;
         ok = (beats[k].w === wen) && (beats[k].addr === ea) && (beats[k].mask === em);
         for (int j = 0; j < 8; j++)
            if (em[j] && beats[k].data[8*j +: 8] !== wdata[8*(8*k+j-off) +: 8]) ok = 1'b0;
         n_checks++;
         if (!ok)
            $display("FAIL %s beat%0d: got w=%b addr=%h mask=%h data=%h, required w=%b addr=%h mask=%h",
                     name, k, beats[k].w, beats[k].addr, beats[k].mask, beats[k].data, wen, ea, em);
         else
            n_pass++;
      end
   endtask

   task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                          output logic [63:0] rdata, output logic err, output int lat);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b, required 1", req_ready);
      else n_pass++;
      beats.delete();
      req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      rdata = resp_rdata;
      err = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err || req_ready !== 1'b0)
            $display("FAIL hold_stable: cycle %0d valid=%b rdata=%h ready=%b, required valid=1 rdata=%h ready=0",
                     i, resp_valid, resp_rdata, req_ready, rdata);
         else
            n_pass++;
      end
      resp_ready = 1'b1;
      n_txn++;
      $display("txn %0d: wen=%b size=%0d uns=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d beats=%0d",
               n_txn, wen, size, uns, addr, wdata, rdata, err, lat, beats.size());
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", req_ready); else n_pass++;
      n_checks++;
      if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0)
         $display("FAIL reset_resp: valid=%b err=%b rdata=%h, required 0", resp_valid, resp_err, resp_rdata);
      else n_pass++;
      n_checks++;
      if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_raddr !== 64'd0 || mem_waddr !== 64'd0 ||
          mem_wdata !== 64'd0 || mem_wmask !== 8'd0)
         $display("FAIL reset_mem: ren=%b wen=%b wmask=%h, required all 0", mem_ren, mem_wen, mem_wmask);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_aligned();
      logic [63:0] rd; logic er; int lat;
      poke(1, 64'h1122_3344_5566_7788);
      run_req(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0 || lat != 2)
         $display("FAIL ld_aligned: rdata=%h err=%b lat=%0d, required 1122334455667788 0 2", rd, er, lat);
      else n_pass++;
      check_beats("ld_aligned", 1'b0, 2'd3, 64'h8000_0008, 64'd0);
   endtask

   task automatic test_load_byte();
      logic [63:0] rd; logic er; int lat;
      poke(0, 64'hA1B2_C3D4_80E5_F607);
      run_req(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'hFFFF_FFFF_FFFF_FF80 || lat != 2)
         $display("FAIL lb_signed: rdata=%h lat=%0d, required ffffffffffffff80 2", rd, lat);
      else n_pass++;
      run_req(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'h0000_0000_0000_0080)
         $display("FAIL lbu: rdata=%h, required 0000000000000080", rd);
      else n_pass++;
   endtask

   task automatic test_store_half();
      logic [63:0] rd; logic er; int lat;
      run_req(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hBEEF, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'd0 || er !== 1'b0 || lat != 2)
         $display("FAIL sh_resp: rdata=%h err=%b lat=%0d, required 0 0 2", rd, er, lat);
      else n_pass++;
      n_checks++;
      if (beats.size() != 1 || beats[0].addr !== 64'h8000_0000 || beats[0].mask !== 8'hC0 ||
          beats[0].data !== 64'hBEEF_0000_0000_0000)
         $display("FAIL sh_beat: n=%0d addr=%h mask=%h data=%h, required 1 80000000 c0 beef000000000000",
                  beats.size(), beats[0].addr, beats[0].mask, beats[0].data);
      else n_pass++;
      model_store(64'h8000_0006, 2'd1, 64'hBEEF);
      check_mem("sh");
   endtask

   task automatic test_store_split();
      logic [63:0] rd; logic er; int lat;
      run_req(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hDEAD_BEEF, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'd0 || er !== 1'b0 || lat != 3)
         $display("FAIL sw_split_resp: rdata=%h err=%b lat=%0d, required 0 0 3", rd, er, lat);
      else n_pass++;
      n_checks++;
      if (beats.size() != 2)
         $display("FAIL sw_split_beats: got %0d beats, required 2", beats.size());
      else if (beats[0].addr !== 64'h8000_0000 || beats[0].mask !== 8'hC0 || beats[0].data !== 64'hBEEF_0000_0000_0000 ||
               beats[1].addr !== 64'h8000_0008 || beats[1].mask !== 8'h03 || beats[1].data !== 64'hDEAD)
         $display("FAIL sw_split_beats: b0 %h/%h/%h b1 %h/%h/%h, required 80000000/c0/beef<<48 80000008/03/dead",
                  beats[0].addr, beats[0].mask, beats[0].data, beats[1].addr, beats[1].mask, beats[1].data);
      else n_pass++;
      model_store(64'h8000_0006, 2'd2, 64'hDEAD_BEEF);
      check_mem("sw_split");
   endtask

   task automatic test_load_split();
      logic [63:0] rd; logic er; int lat;
      poke(0, 64'hAABB_CCDD_EEFF_0011);
      poke(1, 64'h0102_0304_0506_0708);
      run_req(1'b0, 2'd3, 1'b0, 64'h8000_0005, 64'd0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 64'h0405_0607_08AA_BBCC || er !== 1'b0 || lat != 3)
         $display("FAIL ld_split: rdata=%h err=%b lat=%0d, required 0405060708aabbcc 0 3", rd, er, lat);
      else n_pass++;
      check_beats("ld_split", 1'b0, 2'd3, 64'h8000_0005, 64'd0);
   endtask

   task automatic test_split_refused();
      int lat; logic strobe_seen;
      @(negedge clk);
      req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h8000_0005;
      ns_req_valid = 1'b1; ns_resp_ready = 1'b1;
      n_checks++;
      if (ns_req_ready !== 1'b1) $display("FAIL ns_ready: got %b, required 1", ns_req_ready); else n_pass++;
      lat = 0; strobe_seen = 1'b0;
      do begin
         @(negedge clk);
         ns_req_valid = 1'b0;
         lat++;
         if (ns_mem_ren || ns_mem_wen) strobe_seen = 1'b1;
      end while (ns_resp_valid !== 1'b1 && lat < 10);
      n_checks++;
      if (ns_resp_err !== 1'b1 || strobe_seen !== 1'b0 || lat != 2)
         $display("FAIL split_refused: err=%b strobe=%b lat=%0d, required err=1 strobe=0 lat=2", ns_resp_err, strobe_seen, lat);
      else n_pass++;
      @(negedge clk);
      ns_resp_ready = 1'b0;
      n_checks++;
      if (ns_resp_valid !== 1'b0 || ns_resp_err !== 1'b0 || ns_req_ready !== 1'b1)
         $display("FAIL split_refused_done: valid=%b err=%b ready=%b, required 0 0 1", ns_resp_valid, ns_resp_err, ns_req_ready);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      logic [63:0] rd, exp; logic er; int lat;
      exp = model_load(64'h8000_0010, 2'd2, 1'b0);
      run_req(1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'd0, 4, rd, er, lat);
      n_checks++;
      if (rd !== exp || lat != 2)
         $display("FAIL back_pressure: rdata=%h lat=%0d, required %h 2", rd, lat, exp);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [63:0] rd, wd, exp; logic er; int lat;
      wd = {$urandom, $urandom};
      run_req(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, wd, 0, rd, er, lat);
      check_beats("wrap_sd", 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFC, wd);
      model_store(64'hFFFF_FFFF_FFFF_FFFC, 2'd3, wd);
      check_mem("wrap_sd");
      exp = model_load(64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b0);
      run_req(1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 0, rd, er, lat);
      n_checks++;
      if (rd !== exp || lat != 3)
         $display("FAIL wrap_lw: rdata=%h lat=%0d, required %h 3", rd, lat, exp);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      poke(0, 64'd0);
      poke(1, 64'h5555_5555_5555_5555);
      @(negedge clk);
      beats.delete();
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 64'h8000_0006; req_wdata = 64'h1122_3344; resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_wen !== 1'b0 || mem_ren !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL reset_mid: wen=%b ren=%b ready=%b valid=%b, required 0 0 1 0", mem_wen, mem_ren, req_ready, resp_valid);
      else n_pass++;
      n_checks++;
      if (beats.size() != 1) $display("FAIL reset_mid_beats: got %0d beats, required 1", beats.size());
      else n_pass++;
      ref_bytes[6] = 8'h44;
      ref_bytes[7] = 8'h33;
      check_mem("reset_mid");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic wen, uns; logic [1:0] size; logic [63:0] addr, wdata, rd, exp; logic er;
      int lat, hold, exp_lat;
      for (int t = 0; t < 60; t++) begin
         wen = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) addr = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
         else addr = 64'h8000_0000 + 64'($urandom_range(0, 127));
         wdata = {$urandom, $urandom};
         hold = $urandom_range(0, 2);
         exp = wen ? 64'd0 : model_load(addr, size, uns);
         exp_lat = (int'(addr[2:0]) + (1 << size) > 8) ? 3 : 2;
         run_req(wen, size, uns, addr, wdata, hold, rd, er, lat);
         n_checks++;
         if (rd !== exp || er !== 1'b0 || lat != exp_lat)
            $display("FAIL rand_resp %0d: rdata=%h err=%b lat=%0d, required %h 0 %0d", t, rd, er, lat, exp, exp_lat);
         else n_pass++;
         check_beats("rand", wen, size, addr, wdata);
         if (wen) begin
            model_store(addr, size, wdata);
            check_mem("rand");
         end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
      ns_req_valid = 1'b0; ns_resp_ready = 1'b0;
      for (int i = 0; i < 16; i++) poke(i, {$urandom, $urandom});
      test_reset();
      test_load_aligned();
      test_load_byte();
      test_store_half();
      test_store_split();
      test_load_split();
      test_split_refused();
      test_back_pressure();
      test_wrap();
      test_reset_mid();
      test_random();
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
